// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// gray_pkg : shared FSM state encoding and size defaults for gray_pipe_ctrl
// Rev 1.0
// ============================================================================
package gray_pkg;

    localparam int PIPE_DEPTH_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/gray_vld_shift.sv
`default_nettype none
// ============================================================================
// gray_vld_shift : valid / last occupancy shift registers for the gray pipe
// Rev 1.0
// ============================================================================
module gray_vld_shift
    import gray_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_advance,
    input  logic i_flush,
    input  logic i_accept,
    input  logic i_last,
    output logic o_tail_vld,
    output logic o_tail_lst
);

    logic [PIPE_DEPTH-1:0] r_vld;
    logic [PIPE_DEPTH-1:0] r_lst;

    // Flush wins over advance so an aborted frame leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
            r_lst <= '0;
        end else if (i_advance) begin
            r_vld <= {r_vld[PIPE_DEPTH-2:0], i_accept};
            r_lst <= {r_lst[PIPE_DEPTH-2:0], i_accept & i_last};
        end
    end

    assign o_tail_vld = r_vld[PIPE_DEPTH-1];
    assign o_tail_lst = r_lst[PIPE_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gray_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// gray_pipe_ctrl : frame / flow controller for the RGB-to-gray pipeline.
// Optional stall statistics port enabled by GRAY_PIPE_CTRL_STATS_EN.  Rev 1.0
// ============================================================================
module gray_pipe_ctrl
    import gray_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic [CNT_W-1:0] i_frame_len,
    input  logic             i_in_valid,
    input  logic             i_in_last,
    output logic             o_in_ready,
    output logic             o_enable_in,
    output logic             o_enable_out,
    output logic             o_conv_clr,
    output logic             o_out_valid,
    output logic             o_out_last,
    input  logic             i_out_ready,
    output logic             o_frame_done,
    output logic             o_frame_err,
    output logic [CNT_W-1:0] o_pix_cnt
`ifdef GRAY_PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]      o_stall_cnt
`endif
);

    state_t           r_state;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_frame_len;
    logic             r_frame_err;
    logic             r_conv_clr;

    logic             w_tail_vld;
    logic             w_tail_lst;
    logic             w_advance;
    logic             w_accept;
    logic             w_last_done;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_len;

    assign w_advance    = !w_tail_vld || i_out_ready;
    assign o_in_ready   = w_advance && (r_state != ST_DRAIN) && !i_flush;
    assign w_accept     = i_in_valid && o_in_ready;
    assign o_enable_in  = w_advance;
    assign o_enable_out = w_advance;
    assign o_out_valid  = w_tail_vld;
    assign o_out_last   = w_tail_lst && w_tail_vld;
    assign w_last_done  = o_out_last && i_out_ready && !i_flush;
    assign o_frame_done = w_last_done && (r_state == ST_DRAIN);
    assign o_frame_err  = r_frame_err;
    assign o_conv_clr   = r_conv_clr;
    assign o_pix_cnt    = r_pix_cnt;

    assign w_cnt_inc = (&r_pix_cnt) ? r_pix_cnt : r_pix_cnt + CNT_W'(1);
    // The first pixel of a frame compares against the live length input.
    assign w_len     = (r_state == ST_IDLE) ? i_frame_len : r_frame_len;

    gray_vld_shift #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_vld_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_advance  (w_advance),
        .i_flush    (i_flush),
        .i_accept   (w_accept),
        .i_last     (i_in_last),
        .o_tail_vld (w_tail_vld),
        .o_tail_lst (w_tail_lst)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pix_cnt   <= '0;
            r_frame_len <= '0;
            r_frame_err <= 1'b0;
            r_conv_clr  <= 1'b0;
        end else begin
            r_conv_clr <= i_flush;
            if (i_flush) begin
                r_state     <= ST_IDLE;
                r_pix_cnt   <= '0;
                r_frame_err <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE:  if (w_accept) r_state <= i_in_last ? ST_DRAIN : ST_RUN;
                    ST_RUN:   if (w_accept && i_in_last) r_state <= ST_DRAIN;
                    ST_DRAIN: if (w_last_done) r_state <= ST_IDLE;
                    default:  r_state <= ST_IDLE;
                endcase

                if (w_accept && (r_state == ST_IDLE))
                    r_frame_len <= i_frame_len;

                if ((r_state == ST_DRAIN) && w_last_done)
                    r_pix_cnt <= '0;
                else if (w_accept)
                    r_pix_cnt <= w_cnt_inc;

                if (w_accept && ((i_in_last && (w_cnt_inc != w_len)) ||
                                 (!i_in_last && (w_cnt_inc == w_len))))
                    r_frame_err <= 1'b1;
            end
        end
    end

`ifdef GRAY_PIPE_CTRL_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_tail_vld && !i_out_ready)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_gray_pipe_ctrl : self-checking bench for gray_pipe_ctrl (PIPE_DEPTH = 4)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gray_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] flen = 16'd8;
    logic        vin = 1'b0;
    logic        vlast = 1'b0;
    logic        ordy = 1'b1;
    logic        in_ready, en_in, en_out, conv_clr, ov, ol, fd, ferr;
    logic [15:0] pix;
`ifdef GRAY_PIPE_CTRL_STATS_EN
    logic [31:0] stall;
`endif

    gray_pipe_ctrl #(.PIPE_DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_frame_len  (flen),
        .i_in_valid   (vin),
        .i_in_last    (vlast),
        .o_in_ready   (in_ready),
        .o_enable_in  (en_in),
        .o_enable_out (en_out),
        .o_conv_clr   (conv_clr),
        .o_out_valid  (ov),
        .o_out_last   (ol),
        .i_out_ready  (ordy),
        .o_frame_done (fd),
        .o_frame_err  (ferr),
        .o_pix_cnt    (pix)
`ifdef GRAY_PIPE_CTRL_STATS_EN
        ,
        .o_stall_cnt  (stall)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit sb_q[$];

    typedef struct packed {
        logic        v, l, r;
        logic        e_rdy, e_en, e_ov, e_ol, e_fd;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic l, logic r, logic rdy, logic en,
                                logic o_v, logic o_l, logic f_d, logic [15:0] c);
        vec_t t;
        t = '{v: v, l: l, r: r, e_rdy: rdy, e_en: en, e_ov: o_v, e_ol: o_l, e_fd: f_d, e_cnt: c};
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then track beats.
    task automatic step(input logic v, input logic l, input logic r, input logic f,
                        input logic [15:0] len);
        @(negedge clk);
        vin = v; vlast = l; ordy = r; flush = f; flen = len;
        #1;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (ov && ordy) begin
                if (sb_q.size() == 0) chk("sb_unexpected_beat", ov, 1'b0);
                else                  chk("sb_out_last", ol, sb_q.pop_front());
            end
            if (vin && in_ready) sb_q.push_back(vlast);
        end
    endtask

    initial begin
        int fd_seen;
        int ov_seen;

        // 8-pixel frame, then the same frame with a 3-cycle downstream stall
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd0));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd1));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd2));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd3));
        tbl.push_back(mk(1,0,1, 1,1,1,0,0, 16'd4));
        tbl.push_back(mk(1,0,1, 1,1,1,0,0, 16'd5));
        tbl.push_back(mk(1,0,1, 1,1,1,0,0, 16'd6));
        tbl.push_back(mk(1,1,1, 1,1,1,0,0, 16'd7));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0, 16'd8));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0, 16'd8));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0, 16'd8));
        tbl.push_back(mk(0,0,1, 0,1,1,1,1, 16'd8));
        tbl.push_back(mk(0,0,1, 1,1,0,0,0, 16'd0));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd0));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd1));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd2));
        tbl.push_back(mk(1,0,1, 1,1,0,0,0, 16'd3));
        tbl.push_back(mk(1,0,1, 1,1,1,0,0, 16'd4));
        tbl.push_back(mk(1,0,0, 0,0,1,0,0, 16'd5));
        tbl.push_back(mk(1,0,0, 0,0,1,0,0, 16'd5));
        tbl.push_back(mk(1,0,0, 0,0,1,0,0, 16'd5));
        tbl.push_back(mk(1,0,1, 1,1,1,0,0, 16'd5));
        tbl.push_back(mk(1,0,1, 1,1,1,0,0, 16'd6));
        tbl.push_back(mk(1,1,1, 1,1,1,0,0, 16'd7));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0, 16'd8));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0, 16'd8));
        tbl.push_back(mk(0,0,1, 0,1,1,0,0, 16'd8));
        tbl.push_back(mk(0,0,1, 0,1,1,1,1, 16'd8));
        tbl.push_back(mk(0,0,1, 1,1,0,0,0, 16'd0));

        // Reset values while held and just after release
        #12;
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_pix_cnt", pix, 16'd0);
        chk("rst_frame_err", ferr, 1'b0);
        chk("rst_frame_done", fd, 1'b0);
        chk("rst_conv_clr", conv_clr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);
        chk("rel_enable_in", en_in, 1'b1);
        chk("rel_enable_out", en_out, 1'b1);
        chk("rel_out_valid", ov, 1'b0);

        // Length is only sampled on the first pixel; later rows drive a wrong one
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].l, tbl[i].r, 1'b0, (tbl[i].e_cnt == 16'd0) ? 16'd8 : 16'd5);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_enable_in", i), en_in, tbl[i].e_en);
            chk($sformatf("tbl%0d_enable_out", i), en_out, tbl[i].e_en);
            chk($sformatf("tbl%0d_out_valid", i), ov, tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_last", i), ol, tbl[i].e_ol);
            chk($sformatf("tbl%0d_frame_done", i), fd, tbl[i].e_fd);
            chk($sformatf("tbl%0d_pix_cnt", i), pix, tbl[i].e_cnt);
        end
        chk("tbl_frame_err", ferr, 1'b0);
        chk("tbl_sb_empty", sb_q.size(), 0);
`ifdef GRAY_PIPE_CTRL_STATS_EN
        chk("tbl_stall_cnt", stall, 32'd3);
`endif

        // Short frame: last on pixel 3 of 4 -> sticky error until flush
        step(1, 0, 1, 0, 16'd4);
        step(1, 0, 1, 0, 16'd4);
        step(1, 1, 1, 0, 16'd4);
        fd_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 1, 0, 16'd4);
            chk($sformatf("short_err_c%0d", k), ferr, 1'b1);
            if (fd === 1'b1) fd_seen++;
        end
        chk("short_done_pulses", fd_seen, 1);
        step(0, 0, 1, 1, 16'd4);
        step(0, 0, 1, 0, 16'd4);
        chk("short_err_cleared", ferr, 1'b0);

        // Flush with three pixels in flight
        step(1, 0, 1, 0, 16'd8);
        step(1, 0, 1, 0, 16'd8);
        step(1, 0, 1, 0, 16'd8);
        step(0, 0, 1, 1, 16'd8);
        chk("flush_in_ready", in_ready, 1'b0);
        step(0, 0, 1, 0, 16'd8);
        chk("flush_out_valid", ov, 1'b0);
        chk("flush_conv_clr", conv_clr, 1'b1);
        chk("flush_pix_cnt", pix, 16'd0);
        chk("flush_in_ready_after", in_ready, 1'b1);
        step(0, 0, 1, 0, 16'd8);
        chk("flush_conv_clr_one_cycle", conv_clr, 1'b0);
        fd_seen = 0; ov_seen = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, 0, 16'd8);
            if (fd === 1'b1) fd_seen++;
            if (ov === 1'b1) ov_seen++;
        end
        chk("flush_no_done", fd_seen, 0);
        chk("flush_no_output", ov_seen, 0);

        // Single-pixel frame goes straight to drain
        step(1, 1, 1, 0, 16'd1);
        chk("single_in_ready_c0", in_ready, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 1, 0, 16'd1);
            chk($sformatf("single_in_ready_c%0d", k), in_ready, 1'b0);
            chk($sformatf("single_done_c%0d", k), fd, (k == 4) ? 1'b1 : 1'b0);
            chk($sformatf("single_last_c%0d", k), ol, (k == 4) ? 1'b1 : 1'b0);
        end
        step(0, 0, 1, 0, 16'd1);
        chk("single_in_ready_c5", in_ready, 1'b1);
        chk("single_err", ferr, 1'b0);
        chk("single_sb_empty", sb_q.size(), 0);

        // Asynchronous reset mid-frame with the error flag set
        step(1, 0, 1, 0, 16'd1);
        step(1, 0, 1, 0, 16'd1);
        step(0, 0, 1, 0, 16'd1);
        chk("midrst_err_before", ferr, 1'b1);
        chk("midrst_cnt_before", pix, 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ov, 1'b0);
        chk("midrst_pix_cnt", pix, 16'd0);
        chk("midrst_frame_err", ferr, 1'b0);
        chk("midrst_frame_done", fd, 1'b0);
        chk("midrst_conv_clr", conv_clr, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_enable_in", en_in, 1'b1);
        fd_seen = 0; ov_seen = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 1, 0, 16'd8);
            if (fd === 1'b1) fd_seen++;
            if (ov === 1'b1) ov_seen++;
        end
        chk("midrst_no_done", fd_seen, 0);
        chk("midrst_no_output", ov_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_pipe_ctrl.md
GRAY_PIPE_CTRL -- requirements
Module: gray_pipe_ctrl

Interface
REQ-001 Parameters SHALL be: PIPE_DEPTH, 4, register stages in the controlled RGB-to-gray datapath (>=2); CNT_W, 16, pixel-counter width.
REQ-002 CLK  in  1  single clock; all logic rising-edge.
REQ-003 CLEAR  in  1  asynchronous, active-low reset.
REQ-004 FLUSH  in  1  synchronous abort of current frame.
REQ-005 FRAME_LEN  in  CNT_W  expected pixels per frame; sampled on the first accepted pixel.
REQ-006 IN_VALID / IN_LAST  in  1 / 1  upstream pixel valid / last pixel of frame.
REQ-007 IN_READY  out  1  pixel accepted when IN_VALID && IN_READY.
REQ-008 ENABLE_IN  out  1  advance enable for the int-to-float converter stages.
REQ-009 ENABLE_OUT  out  1  advance enable for the output pipeline registers.
REQ-010 CONV_CLR  out  1  one-cycle clear pulse to the converter datapath.
REQ-011 OUT_VALID / OUT_LAST  out  1 / 1  gray result valid / last of frame.
REQ-012 OUT_READY  in  1  downstream accepts when OUT_VALID && OUT_READY.
REQ-013 FRAME_DONE  out  1  one-cycle pulse when the last pixel is consumed downstream.
REQ-014 FRAME_ERR  out  1  sticky length-mismatch flag, cleared by FLUSH or reset.
REQ-015 PIX_CNT  out  CNT_W  pixels accepted in the current frame.

Function
REQ-016 Occupancy SHALL be tracked by PIPE_DEPTH-bit shift registers vld and lst; advance = !vld[PIPE_DEPTH-1] || OUT_READY.
REQ-017 ENABLE_IN = ENABLE_OUT = advance; on advance vld shifts in the accept strobe and lst shifts in IN_LAST of the accepted pixel.
REQ-018 OUT_VALID = vld[PIPE_DEPTH-1]; OUT_LAST = lst[PIPE_DEPTH-1] && OUT_VALID.
REQ-019 Unstalled latency SHALL be exactly PIPE_DEPTH cycles from accept to OUT_VALID; full throughput one pixel per cycle.
REQ-020 FSM states IDLE, RUN, DRAIN: IDLE->RUN on accept without IN_LAST; IDLE/RUN->DRAIN on accept with IN_LAST; DRAIN->IDLE when OUT_LAST is consumed, pulsing FRAME_DONE that cycle.
REQ-021 IN_READY = advance && state != DRAIN && !FLUSH.
REQ-022 PIX_CNT increments per accept, saturates at all-ones, resets to 0 on entry to IDLE.
REQ-023 FRAME_ERR SHALL set when IN_LAST is accepted with count != FRAME_LEN, or when count reaches FRAME_LEN without IN_LAST.
REQ-024 FLUSH (highest priority, overrides accept and advance) SHALL clear vld, lst and PIX_CNT, force IDLE, pulse CONV_CLR next cycle; no FRAME_DONE.
REQ-025 OUT_READY low with OUT_VALID high SHALL freeze vld, lst and both enables; OUT_VALID and OUT_LAST held stable.
REQ-026 Single-pixel frame (IN_LAST on first accept) SHALL go IDLE->DRAIN directly.

Reset
REQ-027 CLEAR low SHALL asynchronously force IDLE, vld=0, lst=0, PIX_CNT=0, FRAME_ERR=0, FRAME_DONE=0, CONV_CLR=0, STALL_CNT=0; IN_READY, ENABLE_IN, ENABLE_OUT read 1 and OUT_VALID 0 after release.
REQ-028 Reset mid-frame SHALL discard all in-flight pixels; no FRAME_DONE follows.

Configuration
REQ-029 With GRAY_PIPE_CTRL_STATS_EN defined, output STALL_CNT (32 bits) SHALL count cycles with OUT_VALID && !OUT_READY, wrapping, cleared by reset only; without it the port and counter SHALL not exist.

Structure
REQ-030 Shared package gray_pkg SHALL hold the FSM state enum and PIPE_DEPTH/CNT_W defaults.
REQ-031 Sub-module gray_vld_shift SHALL implement the vld/lst occupancy shift registers with advance and flush inputs.

Verification (PIPE_DEPTH=4)
REQ-032 Continuous 8 pixels, OUT_READY=1, FRAME_LEN=8 -> OUT_VALID at cycles 4..11, OUT_LAST at 11, FRAME_DONE at 11, FRAME_ERR=0.
REQ-033 Full pipe, OUT_READY low 3 cycles -> IN_READY, ENABLE_IN, ENABLE_OUT low 3 cycles, no pixel lost or duplicated.
REQ-034 FRAME_LEN=4, IN_LAST on pixel 3 -> FRAME_ERR=1 and stays 1 until FLUSH.
REQ-035 FLUSH with 3 pixels in flight -> OUT_VALID=0 next cycle, CONV_CLR pulse, state IDLE, PIX_CNT=0.
REQ-036 Single pixel with IN_LAST -> IN_READY=0 for cycles 1..4, FRAME_DONE at cycle 4.
REQ-037 CLEAR asserted mid-frame -> all outputs at reset values immediately, no FRAME_DONE after release.
